vga_rect_ctl: RTL
=================

Name: vga_rect_ctl

Overview:
Frame-synchronous position controller for the rectangle/sprite draw stage of the VGA pipeline.
- Follows the mouse, drops the rectangle under gravity on a left click, and parks it on the floor.
- Drives xpos/ypos to the draw stage. Values change only at the start of vertical blanking, so the sprite never tears mid-frame.
- Sits between the mouse interface and the draw stage, in the pclk domain.

Parameters:
SCREEN_W, 800, visible width in pixels
SCREEN_H, 600, visible height in pixels
RECT_W, 48, rectangle width in pixels
RECT_H, 64, rectangle height in pixels
FALL_ACCEL, 1, velocity increment per frame (px/frame²)
VEL_MAX, 16, velocity ceiling (px/frame)

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
mouse_xpos  in  12  mouse x, pclk domain
mouse_ypos  in  12  mouse y, pclk domain
mouse_left  in  1  left button level, asynchronous to pclk
vblnk  in  1  vertical blank from the timing generator
xpos_out  out  12  rectangle left edge
ypos_out  out  12  rectangle top edge
busy  out  1  high while in FALL (or RISE)

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state=FOLLOW, xpos_out=0, ypos_out=0, busy=0
  - vel=0, click_pend=0, sync/edge flops=0
- Frame tick: one-cycle pulse on the cycle after vblnk rises (vblnk & ~vblnk_d).
- mouse_left handling:
  - Passes through a 2-flop synchroniser, then rising-edge detection.
  - An edge sets click_pend. click_pend clears on the next tick.
  - Edge and tick in the same cycle: the click is consumed at that tick.
- All state, velocity and position updates happen only on tick. Outputs are registered and valid 1 cycle after tick.
- Clamping: xmax=SCREEN_W-RECT_W (752), ymax=SCREEN_H-RECT_H (536). Widths are 12-bit unsigned.
- FOLLOW:
  - On tick, xpos=min(mouse_xpos,xmax), ypos=min(mouse_ypos,ymax).
  - If click_pend: go to FALL with vel=0, position frozen at the current values (not updated this tick).
- FALL:
  - On tick, vel_n=min(vel+FALL_ACCEL,VEL_MAX) and y_n=ypos+vel_n, computed 13-bit to avoid overflow.
  - If y_n>=ymax: ypos=ymax, then go to LANDED (or bounce, see Optional Feature). Otherwise ypos=y_n.
  - xpos is held. Clicks are ignored and click_pend is cleared.
- LANDED: position held. click_pend on tick → FOLLOW, vel=0.
- busy=1 in FALL/RISE, 0 otherwise.
- vblnk held high or low indefinitely: no ticks, so no motion.

Optional Feature:
Macro VGA_RECT_CTL_BOUNCE_EN.
- Defined:
  - On floor impact with vel_n>=4: vel=vel_n>>1, enter RISE.
  - RISE, each tick: ypos=ypos-vel saturating at 0, then vel=vel-FALL_ACCEL. When vel reaches 0, enter FALL.
  - Impact with vel_n<4 → LANDED.
- Undefined: RISE state and logic are absent; every impact → LANDED.

Decomposition:
- Package vga_pkg: SCREEN_W/SCREEN_H constants, the 12-bit coordinate typedef, and the state enum (FOLLOW, FALL, LANDED, RISE).
- One sub-module, vga_sync_edge: 2-flop synchroniser plus rising-edge pulse, with async active-low reset. Instantiated for mouse_left; vblnk uses edge detection only.

Test Plan:
- Reset: assert rst_n=0 mid-FALL → outputs immediately 0/0, busy=0. After release, state is FOLLOW.
- Follow with clamp: mouse=(900,700), one vblnk rise → xpos_out=752, ypos_out=536, 1 cycle after tick.
- Drop (bounce off): mouse=(100,100) in FOLLOW, click, then ticks → y sequence:
  - 100 (click tick), 101, 103, 106, 110, … with vel saturating at 16.
  - Ends with ypos=536 and LANDED; busy falls on the same update.
- Click between ticks plus click coincident with tick: each is consumed exactly once. A click during FALL has no effect.
- LANDED click → FOLLOW: the next tick tracks the mouse again.
- Bounce (macro on): impact vel 16 → RISE at vel 8, ypos 536→528→521…, back to FALL at vel 0. Final landing with vel<4 → LANDED.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen constants, coordinate type and controller state enum
// Optional feature macro: VGA_RECT_CTL_BOUNCE_EN (adds the RISE state).
package vga_pkg;

    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 600;
    localparam int COORD_W  = 12;

    typedef logic [COORD_W-1:0] coord_t;

`ifdef VGA_RECT_CTL_BOUNCE_EN
    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        FALL   = 2'd1,
        LANDED = 2'd2,
        RISE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        FALL   = 2'd1,
        LANDED = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - optional 2-flop synchroniser followed by a rising-edge pulse
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   i_din  in  input level (asynchronous when SYNC_EN=1)
//   o_rise out one-cycle pulse in the cycle the (synchronised) level first reads high
module vga_sync_edge #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_rise
);

    logic w_level;
    logic r_prev;

    generate
        if (SYNC_EN) begin : g_sync
            logic r_meta;
            logic r_sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                end else begin
                    r_meta <= i_din;
                    r_sync <= r_meta;
                end
            end
            assign w_level = r_sync;
        end else begin : g_direct
            assign w_level = i_din;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_rise = w_level & ~r_prev;

endmodule

// File: rtl/vga_rect_ctl.sv
// rtl/vga_rect_ctl.sv - frame-synchronous rectangle position controller (follow / fall / land)
// Optional feature macro: VGA_RECT_CTL_BOUNCE_EN (floor bounce via RISE state).
// Ports:
//   pclk        in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   mouse_xpos  in   mouse x (pclk domain)
//   mouse_ypos  in   mouse y (pclk domain)
//   mouse_left  in   left button level, asynchronous
//   vblnk       in   vertical blank
//   xpos_out    out  rectangle left edge
//   ypos_out    out  rectangle top edge
//   busy        out  high while falling (or rising)
module vga_rect_ctl
    import vga_pkg::*;
#(
    parameter int RECT_W     = 48,
    parameter int RECT_H     = 64,
    parameter int FALL_ACCEL = 1,
    parameter int VEL_MAX    = 16
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] mouse_xpos,
    input  logic [COORD_W-1:0] mouse_ypos,
    input  logic               mouse_left,
    input  logic               vblnk,
    output logic [COORD_W-1:0] xpos_out,
    output logic [COORD_W-1:0] ypos_out,
    output logic               busy
);

    localparam coord_t XMAX  = coord_t'(SCREEN_W - RECT_W);
    localparam coord_t YMAX  = coord_t'(SCREEN_H - RECT_H);
    localparam int     VEL_W = $clog2(VEL_MAX + 1);

    typedef logic [VEL_W-1:0] vel_t;

    localparam vel_t VMAX  = vel_t'(VEL_MAX);
    localparam vel_t ACCEL = vel_t'(FALL_ACCEL);

    logic   w_click_rise;
    logic   w_tick;
    logic   w_click;
    state_t r_state,      w_state_n;
    coord_t r_xpos,       w_xpos_n;
    coord_t r_ypos,       w_ypos_n;
    vel_t   r_vel,        w_vel_n;
    logic   r_click_pend, w_click_pend_n;

    logic [VEL_W:0]   w_vel_sum;
    vel_t             w_fall_vel;
    logic [COORD_W:0] w_fall_y;
    logic             w_floor;

    vga_sync_edge #(.SYNC_EN(1'b1)) u_click_edge (
        .clk    (pclk),
        .rst_n  (rst_n),
        .i_din  (mouse_left),
        .o_rise (w_click_rise)
    );

    vga_sync_edge #(.SYNC_EN(1'b0)) u_frame_edge (
        .clk    (pclk),
        .rst_n  (rst_n),
        .i_din  (vblnk),
        .o_rise (w_tick)
    );

    // A click edge landing on the tick cycle is seen by that tick.
    assign w_click = r_click_pend | w_click_rise;

    // Fall arithmetic is one bit wider so the floor test cannot wrap.
    assign w_vel_sum  = {1'b0, r_vel} + {1'b0, ACCEL};
    assign w_fall_vel = (w_vel_sum > {1'b0, VMAX}) ? VMAX : w_vel_sum[VEL_W-1:0];
    assign w_fall_y   = {1'b0, r_ypos} + {{(COORD_W + 1 - VEL_W){1'b0}}, w_fall_vel};
    assign w_floor    = (w_fall_y >= {1'b0, YMAX});

`ifdef VGA_RECT_CTL_BOUNCE_EN
    localparam vel_t BOUNCE_MIN = vel_t'(4);
    coord_t w_rise_y;
    vel_t   w_rise_vel;
    assign w_rise_y   = (r_ypos < {{(COORD_W - VEL_W){1'b0}}, r_vel}) ? '0
                        : r_ypos - {{(COORD_W - VEL_W){1'b0}}, r_vel};
    assign w_rise_vel = (r_vel > ACCEL) ? r_vel - ACCEL : '0;
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FOLLOW;
            r_xpos       <= '0;
            r_ypos       <= '0;
            r_vel        <= '0;
            r_click_pend <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_xpos       <= w_xpos_n;
            r_ypos       <= w_ypos_n;
            r_vel        <= w_vel_n;
            r_click_pend <= w_click_pend_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_xpos_n       = r_xpos;
        w_ypos_n       = r_ypos;
        w_vel_n        = r_vel;
        w_click_pend_n = r_click_pend | w_click_rise;
        if (w_tick) begin
            // Every tick consumes any pending click, whatever the state.
            w_click_pend_n = 1'b0;
            case (r_state)
                FOLLOW: begin
                    if (w_click) begin
                        w_state_n = FALL;
                        w_vel_n   = '0;
                    end else begin
                        w_xpos_n = (mouse_xpos > XMAX) ? XMAX : mouse_xpos;
                        w_ypos_n = (mouse_ypos > YMAX) ? YMAX : mouse_ypos;
                    end
                end
                FALL: begin
                    if (w_floor) begin
                        w_ypos_n = YMAX;
`ifdef VGA_RECT_CTL_BOUNCE_EN
                        if (w_fall_vel >= BOUNCE_MIN) begin
                            w_vel_n   = w_fall_vel >> 1;
                            w_state_n = RISE;
                        end else begin
                            w_vel_n   = '0;
                            w_state_n = LANDED;
                        end
`else
                        w_vel_n   = '0;
                        w_state_n = LANDED;
`endif
                    end else begin
                        w_ypos_n = w_fall_y[COORD_W-1:0];
                        w_vel_n  = w_fall_vel;
                    end
                end
                LANDED: begin
                    if (w_click) begin
                        w_state_n = FOLLOW;
                        w_vel_n   = '0;
                    end
                end
`ifdef VGA_RECT_CTL_BOUNCE_EN
                RISE: begin
                    w_ypos_n = w_rise_y;
                    w_vel_n  = w_rise_vel;
                    if (w_rise_vel == '0) begin
                        w_state_n = FALL;
                    end
                end
`endif
                default: begin
                    w_state_n = FOLLOW;
                end
            endcase
        end
    end

    assign xpos_out = r_xpos;
    assign ypos_out = r_ypos;
`ifdef VGA_RECT_CTL_BOUNCE_EN
    assign busy = (r_state == FALL) || (r_state == RISE);
`else
    assign busy = (r_state == FALL);
`endif

endmodule
